// File: rtl/adc_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer_if
//
// Bundles the control, converter and result signals of the ADC scan
// sequencer. The sequencer connects through the slave modport. A controller
// or testbench driving the sequencer uses the master modport.
//
// Parameters
//   NUM_CH  channels per scan; sets the width of the channel fields
//   DATA_W  converter result width
//
// Signals (directions as seen by the sequencer)
//   en_in        in   block enable; low aborts to IDLE
//   start_in     in   scan start request, honoured in IDLE only
//   free_in      in   restart a scan automatically after the last channel
//   eoc_in       in   converter end-of-conversion
//   data_in      in   converter result, valid while eoc_in is high
//   ready_in     in   downstream accepts the held result
//   ch_sel_out   out  analog mux channel select
//   conv_en_out  out  converter enable/track
//   soc_out      out  start-of-conversion pulse
//   data_out     out  captured result
//   ch_out       out  channel tag of data_out
//   valid_out    out  result valid
//   int_out      out  scan-complete pulse
//   overrun_out  out  sticky: an unread result was overwritten
//   timeout_out  out  sticky: the converter never answered
//   state_out    out  current sequencer state
// ---------------------------------------------------------------------------
interface adc_scan_sequencer_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 12
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              en_in;
   logic              start_in;
   logic              free_in;
   logic              eoc_in;
   logic [DATA_W-1:0] data_in;
   logic              ready_in;
   logic [CH_W-1:0]   ch_sel_out;
   logic              conv_en_out;
   logic              soc_out;
   logic [DATA_W-1:0] data_out;
   logic [CH_W-1:0]   ch_out;
   logic              valid_out;
   logic              int_out;
   logic              overrun_out;
   logic              timeout_out;
   logic [2:0]        state_out;

   // Sequencer side
   modport slave (
      input  en_in, start_in, free_in, eoc_in, data_in, ready_in,
      output ch_sel_out, conv_en_out, soc_out, data_out, ch_out,
             valid_out, int_out, overrun_out, timeout_out, state_out
   );

   // Controller side
   modport master (
      output en_in, start_in, free_in, eoc_in, data_in, ready_in,
      input  ch_sel_out, conv_en_out, soc_out, data_out, ch_out,
             valid_out, int_out, overrun_out, timeout_out, state_out
   );
endinterface

// File: rtl/adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer
//
// Scans NUM_CH analog channels in order. Each channel gets a mux select,
// an acquisition window of CAP_CYCLES cycles, a one-cycle start-of-conversion
// pulse, a bounded wait for end-of-conversion, and a one-cycle result store.
// Results leave through a valid/ready holding register. A scan-complete
// pulse follows the last channel. Scans run single-shot or free-running.
//
// Parameters
//   NUM_CH       channels per scan (2..16)
//   DATA_W       converter result width
//   CAP_CYCLES   acquisition cycles per channel before SOC (>= 1)
//   EOC_TIMEOUT  WAIT_EOC cycles without eoc before the scan is abandoned (>= 1)
//
// Ports
//   clk_in  single clock domain
//   rst_in  asynchronous, active-high reset
//   bus     adc_scan_sequencer_if.slave: control inputs, converter handshake,
//           result register and status outputs
//
// Every output is a register or a decode of the state register, so no
// combinational path exists from an input to an output.
// ---------------------------------------------------------------------------
module adc_scan_sequencer #(
   parameter int NUM_CH      = 4,
   parameter int DATA_W      = 12,
   parameter int CAP_CYCLES  = 4,
   parameter int EOC_TIMEOUT = 64
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   adc_scan_sequencer_if.slave   bus
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int ACQ_W = $clog2(CAP_CYCLES + 1);
   localparam int TO_W  = $clog2(EOC_TIMEOUT + 1);

   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(CAP_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(EOC_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACQ      = 3'd1,
      ST_SOC      = 3'd2,
      ST_WAIT_EOC = 3'd3,
      ST_STORE    = 3'd4
   } state_e;

   state_e            state;
   state_e            state_nxt;

   logic [CH_W-1:0]   ch_idx;
   logic [ACQ_W-1:0]  acq_cnt;
   logic [TO_W-1:0]   to_cnt;

   logic [DATA_W-1:0] data_q;
   logic [CH_W-1:0]   ch_q;
   logic              valid_q;
   logic              int_q;
   logic              overrun_q;
   logic              timeout_q;

   // Decoded events for the current cycle, produced alongside the next state
   logic              start_scan;
   logic              load_result;
   logic              eoc_abort;
   logic              scan_done;

   // State register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Dropping en_in overrides everything, including a
   // pending eoc or the final STORE, so an aborted scan never produces a
   // result or a scan-complete pulse.
   always_comb begin
      state_nxt   = ST_IDLE;
      start_scan  = 1'b0;
      load_result = 1'b0;
      eoc_abort   = 1'b0;
      scan_done   = 1'b0;
      if (bus.en_in) begin
         case (state)
            ST_IDLE: begin
               if (bus.start_in) begin
                  state_nxt  = ST_ACQ;
                  start_scan = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_ACQ: begin
               state_nxt = (acq_cnt == ACQ_LAST) ? ST_SOC : ST_ACQ;
            end
            ST_SOC: begin
               state_nxt = ST_WAIT_EOC;
            end
            ST_WAIT_EOC: begin
               if (bus.eoc_in) begin
                  state_nxt   = ST_STORE;
                  load_result = 1'b1;
               end else if (to_cnt == TO_LAST) begin
                  state_nxt = ST_IDLE;
                  eoc_abort = 1'b1;
               end else begin
                  state_nxt = ST_WAIT_EOC;
               end
            end
            ST_STORE: begin
               if (ch_idx == LAST_CH) begin
                  scan_done = 1'b1;
                  state_nxt = bus.free_in ? ST_ACQ : ST_IDLE;
               end else begin
                  state_nxt = ST_ACQ;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Channel index and the two dwell counters. Each counter only runs while
   // its state is being held and is otherwise parked at zero, so every
   // acquisition window and every EOC wait starts counting from zero.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         ch_idx  <= '0;
         acq_cnt <= '0;
         to_cnt  <= '0;
      end else begin
         if (state == ST_ACQ && state_nxt == ST_ACQ) begin
            acq_cnt <= acq_cnt + ACQ_W'(1);
         end else begin
            acq_cnt <= '0;
         end

         if (state == ST_WAIT_EOC && state_nxt == ST_WAIT_EOC) begin
            to_cnt <= to_cnt + TO_W'(1);
         end else begin
            to_cnt <= '0;
         end

         if (!bus.en_in || start_scan) begin
            ch_idx <= '0;
         end else if (state == ST_STORE) begin
            ch_idx <= (ch_idx == LAST_CH) ? '0 : ch_idx + CH_W'(1);
         end
      end
   end

   // Result holding register. A fresh load takes priority over a transfer
   // in the same cycle, so valid stays high and the new word is kept. Only
   // a load over a word that nobody is taking counts as an overrun.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         data_q    <= '0;
         ch_q      <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (load_result) begin
            data_q  <= bus.data_in;
            ch_q    <= ch_idx;
            valid_q <= 1'b1;
            if (valid_q && !bus.ready_in) begin
               overrun_q <= 1'b1;
            end
         end else if (valid_q && bus.ready_in) begin
            valid_q <= 1'b0;
         end

         if (start_scan) begin
            overrun_q <= 1'b0;
         end
      end
   end

   // Scan-complete pulse and the sticky timeout flag. The timeout flag is
   // cleared by the edge that launches the next scan.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         int_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         int_q <= scan_done;
         if (start_scan) begin
            timeout_q <= 1'b0;
         end else if (eoc_abort) begin
            timeout_q <= 1'b1;
         end
      end
   end

   // Converter controls are pure decodes of the state register
   assign bus.ch_sel_out  = ch_idx;
   assign bus.conv_en_out = (state == ST_ACQ) || (state == ST_SOC) ||
                            (state == ST_WAIT_EOC);
   assign bus.soc_out     = (state == ST_SOC);
   assign bus.state_out   = state;

   assign bus.data_out    = data_q;
   assign bus.ch_out      = ch_q;
   assign bus.valid_out   = valid_q;
   assign bus.int_out     = int_q;
   assign bus.overrun_out = overrun_q;
   assign bus.timeout_out = timeout_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_sequencer
//
// Directed bench for adc_scan_sequencer with NUM_CH=4, DATA_W=12,
// CAP_CYCLES=4, EOC_TIMEOUT=64. A scan is launched by the edge that ends
// bench cycle 0, so ACQ occupies cycles 1..4 and SOC is cycle 5. The bench
// converter answers eoc three cycles after each SOC with data base+n.
// ---------------------------------------------------------------------------
module tb_adc_scan_sequencer;

   logic clk_in;
   logic rst_in;

   adc_scan_sequencer_if #(.NUM_CH(4), .DATA_W(12)) bus ();

   adc_scan_sequencer #(
      .NUM_CH      (4),
      .DATA_W      (12),
      .CAP_CYCLES  (4),
      .EOC_TIMEOUT (64)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int vectors;
   int miscompares;

   int cyc;
   int soc_cnt;
   int int_cnt;
   int soc_cyc;
   int first_soc;
   int eoc_idx;
   int eoc_lat;
   bit auto_eoc;
   logic [11:0] data_base;

   int          soc_ch[$];
   int          int_cyc[$];
   int          res_ch[$];
   logic [11:0] res_data[$];

   // One clock: wait for the edge, look at the outputs 1 ns later, then drive
   // this cycle's converter response.
   task automatic step();
      @(posedge clk_in);
      #1;
      cyc++;
      if (bus.soc_out) begin
         soc_cnt++;
         soc_cyc = cyc;
         soc_ch.push_back(int'(bus.ch_sel_out));
         if (first_soc < 0) first_soc = cyc;
      end
      if (bus.int_out) begin
         int_cnt++;
         int_cyc.push_back(cyc);
      end
      if (bus.valid_out && bus.ready_in) begin
         res_ch.push_back(int'(bus.ch_out));
         res_data.push_back(bus.data_out);
      end
      bus.start_in = 1'b0;
      bus.data_in  = data_base + 12'(eoc_idx);
      bus.eoc_in   = auto_eoc && (cyc == soc_cyc + eoc_lat);
      if (bus.eoc_in) eoc_idx++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   // Requests a scan; the following step() edge is edge 0
   task automatic begin_scan(input logic [11:0] base);
      data_base    = base;
      eoc_idx      = 0;
      soc_cnt      = 0;
      int_cnt      = 0;
      soc_cyc      = -100;
      first_soc    = -1;
      soc_ch.delete();
      int_cyc.delete();
      res_ch.delete();
      res_data.delete();
      bus.en_in    = 1'b1;
      bus.start_in = 1'b1;
      cyc          = 0;
      step();
   endtask

   task automatic abort_scan();
      bus.en_in = 1'b0;
      step();
      bus.en_in = 1'b1;
   endtask

   task automatic test_reset();
      vectors++;
      if (bus.state_out !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_state got %0d want 0", bus.state_out); end
      vectors++;
      if ({bus.ch_sel_out, bus.conv_en_out, bus.soc_out, bus.data_out, bus.ch_out, bus.valid_out,
           bus.int_out, bus.overrun_out, bus.timeout_out} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs got data=%h valid=%b conv=%b soc=%b want all 0",
                  bus.data_out, bus.valid_out, bus.conv_en_out, bus.soc_out);
      end
   endtask

   task automatic test_single_shot();
      auto_eoc     = 1'b1;
      bus.ready_in = 1'b1;
      bus.free_in  = 1'b0;
      begin_scan(12'h100);
      vectors++;
      if (bus.state_out !== 3'd1 || bus.conv_en_out !== 1'b1 || bus.ch_sel_out !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL single_acq_entry got state=%0d conv=%b ch=%0d want 1/1/0", bus.state_out, bus.conv_en_out, bus.ch_sel_out);
      end
      run_to(45);
      vectors++;
      if (soc_cnt !== 4) begin miscompares++; $display("[TB] FAIL single_soc_count got %0d want 4", soc_cnt); end
      vectors++;
      if (first_soc !== 5) begin miscompares++; $display("[TB] FAIL single_first_soc got %0d want 5", first_soc); end
      vectors++;
      if (res_ch.size() !== 4) begin
         miscompares++;
         $display("[TB] FAIL single_result_count got %0d want 4", res_ch.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (res_ch[i] !== i || res_data[i] !== 12'h100 + 12'(i)) begin
               miscompares++;
               $display("[TB] FAIL single_result_%0d got ch=%0d data=%h want ch=%0d data=%h", i, res_ch[i], res_data[i], i, 12'h100 + 12'(i));
            end
         end
      end
      vectors++;
      if (int_cnt !== 1 || int_cyc.size() < 1 || int_cyc[0] !== 37) begin
         miscompares++;
         $display("[TB] FAIL single_int got count=%0d want one pulse in cycle 37", int_cnt);
      end
      vectors++;
      if (bus.state_out !== 3'd0) begin miscompares++; $display("[TB] FAIL single_idle got %0d want 0", bus.state_out); end
   endtask

   task automatic test_free_running();
      auto_eoc     = 1'b1;
      bus.ready_in = 1'b1;
      bus.free_in  = 1'b1;
      begin_scan(12'h000);
      run_to(110);
      vectors++;
      if (int_cnt !== 3 || int_cyc.size() !== 3) begin
         miscompares++;
         $display("[TB] FAIL free_int_count got %0d want 3", int_cnt);
      end else begin
         vectors++;
         if (int_cyc[0] !== 37 || int_cyc[1] !== 73 || int_cyc[2] !== 109) begin
            miscompares++;
            $display("[TB] FAIL free_int_cycles got %0d,%0d,%0d want 37,73,109", int_cyc[0], int_cyc[1], int_cyc[2]);
         end
      end
      vectors++;
      if (soc_ch.size() !== 12) begin
         miscompares++;
         $display("[TB] FAIL free_soc_count got %0d want 12", soc_ch.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            vectors++;
            if (soc_ch[i] !== (i % 4)) begin
               miscompares++;
               $display("[TB] FAIL free_soc_ch_%0d got %0d want %0d", i, soc_ch[i], i % 4);
            end
         end
      end
      // Drop enable while channel 0 of the fourth scan is acquiring
      bus.en_in = 1'b0;
      step();
      vectors++;
      if (bus.state_out !== 3'd0 || bus.conv_en_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL free_abort_state got state=%0d conv=%b want 0/0", bus.state_out, bus.conv_en_out);
      end
      for (int i = 0; i < 40; i++) step();
      vectors++;
      if (int_cnt !== 3) begin miscompares++; $display("[TB] FAIL free_abort_int got %0d want 3", int_cnt); end
      bus.free_in = 1'b0;
      bus.en_in   = 1'b1;
      step();
   endtask

   task automatic test_overrun();
      auto_eoc     = 1'b1;
      bus.ready_in = 1'b0;
      begin_scan(12'h200);
      run_to(19);
      vectors++;
      if (bus.data_out !== 12'h201 || bus.ch_out !== 2'd1 || bus.valid_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL overrun_data got data=%h ch=%0d valid=%b want 201/1/1", bus.data_out, bus.ch_out, bus.valid_out);
      end
      vectors++;
      if (bus.overrun_out !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_flag got %b want 1", bus.overrun_out); end
      abort_scan();
      vectors++;
      if (bus.state_out !== 3'd0 || bus.valid_out !== 1'b1 || bus.overrun_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL overrun_after_abort got state=%0d valid=%b ovr=%b want 0/1/1", bus.state_out, bus.valid_out, bus.overrun_out);
      end
      bus.ready_in = 1'b1;
      step();
      vectors++;
      if (bus.valid_out !== 1'b0 || bus.overrun_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL overrun_sticky got valid=%b ovr=%b want 0/1", bus.valid_out, bus.overrun_out);
      end
      begin_scan(12'h000);
      vectors++;
      if (bus.overrun_out !== 1'b0) begin miscompares++; $display("[TB] FAIL overrun_clear_on_start got %b want 0", bus.overrun_out); end
      abort_scan();
   endtask

   task automatic test_load_coincide();
      auto_eoc     = 1'b1;
      bus.ready_in = 1'b0;
      begin_scan(12'h300);
      run_to(17);
      // eoc for channel 1 is high in this cycle; release ready on the same edge
      bus.ready_in = 1'b1;
      step();
      vectors++;
      if (bus.data_out !== 12'h301 || bus.ch_out !== 2'd1 || bus.valid_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL coincide_data got data=%h ch=%0d valid=%b want 301/1/1", bus.data_out, bus.ch_out, bus.valid_out);
      end
      vectors++;
      if (bus.overrun_out !== 1'b0) begin miscompares++; $display("[TB] FAIL coincide_overrun got %b want 0", bus.overrun_out); end
      step();
      vectors++;
      if (bus.valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL coincide_drain got %b want 0", bus.valid_out); end
      abort_scan();
   endtask

   task automatic test_timeout();
      auto_eoc     = 1'b0;
      bus.ready_in = 1'b1;
      begin_scan(12'h000);
      run_to(6);
      vectors++;
      if (bus.state_out !== 3'd3) begin miscompares++; $display("[TB] FAIL timeout_wait_entry got %0d want 3", bus.state_out); end
      run_to(69);
      vectors++;
      if (bus.state_out !== 3'd3 || bus.timeout_out !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL timeout_last_wait got state=%0d to=%b want 3/0", bus.state_out, bus.timeout_out);
      end
      step();
      vectors++;
      if (bus.state_out !== 3'd0 || bus.timeout_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL timeout_abort got state=%0d to=%b want 0/1", bus.state_out, bus.timeout_out);
      end
      step();
      vectors++;
      if (bus.valid_out !== 1'b0 || int_cnt !== 0 || bus.timeout_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL timeout_no_result got valid=%b ints=%0d to=%b want 0/0/1", bus.valid_out, int_cnt, bus.timeout_out);
      end
      begin_scan(12'h000);
      vectors++;
      if (bus.timeout_out !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_clear_on_start got %b want 0", bus.timeout_out); end
      abort_scan();
   endtask

   task automatic test_reset_mid_scan();
      auto_eoc     = 1'b1;
      bus.ready_in = 1'b1;
      begin_scan(12'h400);
      run_to(24);
      vectors++;
      if (bus.state_out !== 3'd3 || bus.ch_sel_out !== 2'd2 || bus.data_out !== 12'h401) begin
         miscompares++;
         $display("[TB] FAIL midreset_pre got state=%0d ch=%0d data=%h want 3/2/401", bus.state_out, bus.ch_sel_out, bus.data_out);
      end
      #2 rst_in = 1'b1;
      #1;
      test_reset();
      #2 rst_in = 1'b0;
      begin_scan(12'h000);
      vectors++;
      if (bus.state_out !== 3'd1 || bus.ch_sel_out !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL midreset_restart got state=%0d ch=%0d want 1/0", bus.state_out, bus.ch_sel_out);
      end
      run_to(6);
      vectors++;
      if (soc_ch.size() !== 1 || soc_ch[0] !== 0) begin
         miscompares++;
         $display("[TB] FAIL midreset_first_soc got %0d pulses want one on ch 0", soc_ch.size());
      end
      abort_scan();
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      cyc          = 0;
      soc_cnt      = 0;
      int_cnt      = 0;
      soc_cyc      = -100;
      first_soc    = -1;
      eoc_idx      = 0;
      eoc_lat      = 3;
      auto_eoc     = 1'b0;
      data_base    = 12'h000;
      rst_in       = 1'b1;
      bus.en_in    = 1'b0;
      bus.start_in = 1'b0;
      bus.free_in  = 1'b0;
      bus.eoc_in   = 1'b0;
      bus.data_in  = 12'h000;
      bus.ready_in = 1'b0;
      #12;
      $display("[TB] power-on reset");
      test_reset();
      #2 rst_in = 1'b0;
      bus.en_in = 1'b1;
      $display("[TB] single-shot scan");
      test_single_shot();
      $display("[TB] free-running scans");
      test_free_running();
      $display("[TB] overrun");
      test_overrun();
      $display("[TB] load coinciding with transfer");
      test_load_coincide();
      $display("[TB] eoc timeout");
      test_timeout();
      $display("[TB] reset during WAIT_EOC");
      test_reset_mid_scan();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
